pc_run_ctrl: RTL
================

PC_RUN_CTRL -- requirements
Module: pc_run_ctrl

Interface
REQ-001 SHALL have parameter CLR_LEN, default 2, giving the number of cycles pc_clr_o is held high per clear (legal 1..15).
REQ-002 SHALL have parameter CNT_W, default 32, giving the width of cycle_cnt_o.
REQ-003 SHALL have port clk_i, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-004 SHALL have port rst_i, input, 1 bit: synchronous, active-high reset.
REQ-005 SHALL have port start_i, input, 1 bit: run/pause request, level from a synchronised board button.
REQ-006 SHALL have port step_i, input, 1 bit: single-instruction step request, level.
REQ-007 SHALL have port clr_i, input, 1 bit: PC clear request, level.
REQ-008 SHALL have port pc_i, input, 32 bits: current PC from the processor top (pc_o).
REQ-009 SHALL have port instr_num_i, input, 32 bits: program length in instructions; end PC is instr_num_i*4.
REQ-010 SHALL have port pc_run_en_o, output, 1 bit: drives the processor top pc_run_en_i.
REQ-011 SHALL have port pc_clr_o, output, 1 bit: drives the processor top pc_clr_i.
REQ-012 SHALL have port state_o, output, 3 bits: current FSM state encoding.
REQ-013 SHALL have port done_o, output, 1 bit: high while the program end has been reached (HALT).
REQ-014 SHALL have port cycle_cnt_o, output, CNT_W bits: count of cycles with pc_run_en_o high.

Function
REQ-015 SHALL register start_i, step_i and clr_i once each and act only on rising edges (current high, registered value low); a held level SHALL act once.
REQ-016 SHALL compute pc_ov = (pc_i[31:2] == instr_num_i[29:0]) combinationally.
REQ-017 SHALL implement the states IDLE=0, RUN=1, STEP=2, HALT=3 and CLEAR=4; codes 5-7 SHALL go to IDLE on the next cycle.
REQ-018 SHALL give edge priority clr > start > step when edges coincide in the same cycle.
REQ-019 SHALL, on a clr edge in any state, enter CLEAR and load the clear counter with CLR_LEN-1.
REQ-020 SHALL, in CLEAR, drive pc_clr_o=1 and pc_run_en_o=0, decrement the clear counter each cycle, and go to IDLE in the cycle after the counter reads 0.
REQ-021 SHALL, in CLEAR, hold cycle_cnt_o at 0; a further clr edge in CLEAR SHALL reload the counter.
REQ-022 SHALL, on a start edge in IDLE, go to RUN if pc_ov=0 and to HALT if pc_ov=1.
REQ-023 SHALL, in RUN, drive pc_run_en_o = ~pc_ov combinationally, so no instruction at or past the end PC is enabled.
REQ-024 SHALL, in RUN, go to HALT on the next edge when pc_ov=1.
REQ-025 SHALL, in RUN, go to IDLE (pause) on a start edge, with pc_ov taking priority over pause.
REQ-026 SHALL, on a step edge in IDLE with pc_ov=0, enter STEP.
REQ-027 SHALL, in STEP, drive pc_run_en_o=1 for exactly one cycle and then return to IDLE; a step edge in IDLE with pc_ov=1 SHALL go to HALT.
REQ-028 SHALL, in HALT, ignore start and step edges; only clr or rst_i exits HALT. done_o SHALL be 1 only in HALT.
REQ-029 SHALL drive pc_run_en_o=0 and pc_clr_o=0 in IDLE and HALT.
REQ-030 SHALL increment cycle_cnt_o by 1 on each edge where pc_run_en_o=1, saturating at all-ones (no wrap).
REQ-031 SHALL sample pc_i and instr_num_i every cycle; instr_num_i=0 SHALL give HALT from PC 0 on the first start.

Reset
REQ-032 SHALL, while rst_i=1 at a clock edge, set state to IDLE, the clear counter to 0, the edge registers to 0 and cycle_cnt_o to 0, overriding all other events.
REQ-033 SHALL give pc_run_en_o=0, pc_clr_o=0, done_o=0 and state_o=0 after reset.
REQ-034 SHALL, if reset is asserted mid-RUN or mid-CLEAR, deassert outputs on the next edge with no residual clear pulse.
REQ-035 SHALL not treat an input level already high at reset release as an edge.

Verification
REQ-036 Reset with instr_num_i=0x12, pulse start, model the PC stepping +4 per enabled cycle from 0 -> run_en high for 18 cycles, run_en drops combinationally at pc=0x48, HALT next edge, done_o=1, cycle_cnt_o=18.
REQ-037 In HALT pulse start and step -> no change; pulse clr -> pc_clr_o high exactly 2 cycles, then IDLE, cycle_cnt_o=0, done_o=0.
REQ-038 From IDLE at pc=0 give 3 step pulses spaced 4 cycles apart -> run_en high for exactly 1 cycle each, pc=0xC, cycle_cnt_o=3.
REQ-039 In RUN at pc=0x20 pulse start -> IDLE, run_en 0; pulse start again -> resumes RUN and halts at 0x48.
REQ-040 Raise clr and start in the same cycle during RUN -> CLEAR wins; assert rst_i in the second CLEAR cycle -> IDLE with pc_clr_o=0 on the next edge.
REQ-041 Hold start_i high for 50 cycles from IDLE -> exactly one transition to RUN; force cycle_cnt_o near saturation with CNT_W=4 -> holds at 15.

Source files
------------

// File: rtl/pc_run_ctrl.sv
// pc_run_ctrl -- run/step/clear controller for a single-cycle processor top.
//
// Watches three board-button levels (start, step, clr), reacts once to each
// rising edge, and sequences the processor's PC enable and PC clear so a
// program of instr_num_i instructions can be run, paused, single-stepped and
// cleared. Halts automatically when the PC reaches the end address.
//
// Parameters:
//   CLR_LEN  cycles pc_clr_o is held high per clear (1..15)
//   CNT_W    width of the enabled-cycle counter
//
// Ports:
//   clk_i        clock, all state changes on the rising edge
//   rst_i        synchronous active-high reset
//   start_i      run/pause request (level)
//   step_i       single-step request (level)
//   clr_i        PC clear request (level)
//   pc_i         current PC from the processor
//   instr_num_i  program length in instructions (end PC = instr_num_i*4)
//   pc_run_en_o  PC/processor enable
//   pc_clr_o     PC clear
//   state_o      current FSM state code
//   done_o       high while halted at program end
//   cycle_cnt_o  saturating count of cycles with pc_run_en_o high

module pc_run_ctrl #(
    parameter int CLR_LEN = 2,
    parameter int CNT_W   = 32
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             start_i,
    input  logic             step_i,
    input  logic             clr_i,
    input  logic [31:0]      pc_i,
    input  logic [31:0]      instr_num_i,
    output logic             pc_run_en_o,
    output logic             pc_clr_o,
    output logic [2:0]       state_o,
    output logic             done_o,
    output logic [CNT_W-1:0] cycle_cnt_o
);

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_RUN   = 3'd1,
        ST_STEP  = 3'd2,
        ST_HALT  = 3'd3,
        ST_CLEAR = 3'd4
    } state_t;

    localparam logic [3:0]       CLR_LOAD = 4'(CLR_LEN - 1);
    localparam logic [CNT_W-1:0] CNT_MAX  = {CNT_W{1'b1}};
    localparam logic [CNT_W-1:0] CNT_ONE  = {{(CNT_W-1){1'b0}}, 1'b1};

    state_t           state_r;
    state_t           state_nxt_s;
    logic [3:0]       clr_cnt_r;
    logic [3:0]       clr_cnt_nxt_s;
    logic [CNT_W-1:0] cycle_cnt_r;
    logic [CNT_W-1:0] cycle_cnt_nxt_s;
    logic             start_q_r;
    logic             step_q_r;
    logic             clr_q_r;
    // Low for the first cycle after reset so a level already high at
    // release is captured into the edge registers instead of acting.
    logic             armed_r;

    logic             pc_ov_s;
    logic             start_edge_s;
    logic             step_edge_s;
    logic             clr_edge_s;
    logic             run_en_s;
    logic             unused_bits_s;

    // PC is word aligned; only the word index is compared with the length.
    assign pc_ov_s       = (pc_i[31:2] == instr_num_i[29:0]);
    assign unused_bits_s = ^{pc_i[1:0], instr_num_i[31:30]};

    assign start_edge_s = armed_r & start_i & ~start_q_r;
    assign step_edge_s  = armed_r & step_i  & ~step_q_r;
    assign clr_edge_s   = armed_r & clr_i   & ~clr_q_r;

    // State, clear counter, edge registers and cycle counter.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_r     <= ST_IDLE;
            clr_cnt_r   <= 4'd0;
            cycle_cnt_r <= {CNT_W{1'b0}};
            start_q_r   <= 1'b0;
            step_q_r    <= 1'b0;
            clr_q_r     <= 1'b0;
            armed_r     <= 1'b0;
        end else begin
            state_r     <= state_nxt_s;
            clr_cnt_r   <= clr_cnt_nxt_s;
            cycle_cnt_r <= cycle_cnt_nxt_s;
            start_q_r   <= start_i;
            step_q_r    <= step_i;
            clr_q_r     <= clr_i;
            armed_r     <= 1'b1;
        end
    end

    // Next-state and clear-counter logic; clr beats start beats step.
    always_comb begin
        state_nxt_s   = state_r;
        clr_cnt_nxt_s = clr_cnt_r;
        if (clr_edge_s) begin
            state_nxt_s   = ST_CLEAR;
            clr_cnt_nxt_s = CLR_LOAD;
        end else begin
            case (state_r)
                ST_IDLE: begin
                    if (start_edge_s) begin
                        state_nxt_s = pc_ov_s ? ST_HALT : ST_RUN;
                    end else if (step_edge_s) begin
                        state_nxt_s = pc_ov_s ? ST_HALT : ST_STEP;
                    end else begin
                        state_nxt_s = ST_IDLE;
                    end
                end
                ST_RUN: begin
                    // Reaching the end wins over a pause request.
                    if (pc_ov_s) begin
                        state_nxt_s = ST_HALT;
                    end else if (start_edge_s) begin
                        state_nxt_s = ST_IDLE;
                    end else begin
                        state_nxt_s = ST_RUN;
                    end
                end
                ST_STEP: begin
                    state_nxt_s = ST_IDLE;
                end
                ST_HALT: begin
                    state_nxt_s = ST_HALT;
                end
                ST_CLEAR: begin
                    if (clr_cnt_r == 4'd0) begin
                        state_nxt_s = ST_IDLE;
                    end else begin
                        clr_cnt_nxt_s = clr_cnt_r - 4'd1;
                    end
                end
                default: begin
                    state_nxt_s   = ST_IDLE;
                    clr_cnt_nxt_s = 4'd0;
                end
            endcase
        end
    end

    // Enable decode; in RUN the enable drops in the same cycle the end PC
    // appears so the instruction at the end address never executes.
    always_comb begin
        run_en_s = 1'b0;
        case (state_r)
            ST_RUN:  run_en_s = ~pc_ov_s;
            ST_STEP: run_en_s = 1'b1;
            default: run_en_s = 1'b0;
        endcase
    end

    // Enabled-cycle counter: zeroed by a clear, saturates at all ones.
    always_comb begin
        cycle_cnt_nxt_s = cycle_cnt_r;
        if (clr_edge_s || (state_r == ST_CLEAR)) begin
            cycle_cnt_nxt_s = {CNT_W{1'b0}};
        end else if (run_en_s && (cycle_cnt_r != CNT_MAX)) begin
            cycle_cnt_nxt_s = cycle_cnt_r + CNT_ONE;
        end else begin
            cycle_cnt_nxt_s = cycle_cnt_r;
        end
    end

    // Output decode from the state register.
    always_comb begin
        pc_run_en_o = run_en_s;
        pc_clr_o    = (state_r == ST_CLEAR);
        done_o      = (state_r == ST_HALT);
        state_o     = state_r;
        cycle_cnt_o = cycle_cnt_r;
    end

endmodule
